// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/execute controller for the 8-bit ALU.
// Fetches two-byte instructions (opcode, operand) from a synchronous memory with
// one cycle of read latency, writes ALU results back into AC, performs stores and
// resolves conditional branches from the ALU flags.
// Build option: SEQ_ILLEGAL_TRAP_EN -- an undefined opcode halts the sequencer
// instead of executing as a NOP.
module alu_sequencer #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_rdata,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  output logic [7:0] alu_opcode,
  output logic [7:0] alu_mdr,
  output logic [7:0] alu_ac,
  output logic [7:0] alu_value,
  output logic [7:0] alu_pc,
  output logic [7:0] alu_addr,
  input  logic [7:0] alu_zout,
  input  logic       alu_nflg,
  input  logic       alu_zflg,
  output logic       halted,
  output logic       illegal
);

  // The capture states assume read data arrives exactly one cycle after mem_rd.
  if (MEM_LAT != 1) begin : g_lat_check
    $error("alu_sequencer: only MEM_LAT=1 is supported");
  end

  typedef enum logic [2:0] {
    StFetch0,
    StFetch1,
    StFetch2,
    StMemRd,
    StMemCap,
    StExec,
    StHalt
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] opnd_q, opnd_d;
  logic [7:0] mdr_q, mdr_d;
  logic [7:0] ac_q, ac_d;
  logic       illegal_q, illegal_d;

  // Opcodes whose operand is an address that must be read into MDR before EXEC.
  function automatic logic is_mem_op(input logic [7:0] op);
    case (op)
      8'h01, 8'h05, 8'h07, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D: is_mem_op = 1'b1;
      default:                                                  is_mem_op = 1'b0;
    endcase
  endfunction

  // State and datapath registers; reset drops any in-flight access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch0;
      pc_q      <= RESET_PC;
      ir_q      <= 8'h00;
      opnd_q    <= 8'h00;
      mdr_q     <= 8'h00;
      ac_q      <= 8'h00;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      opnd_q    <= opnd_d;
      mdr_q     <= mdr_d;
      ac_q      <= ac_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state, datapath updates and memory strobes.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    opnd_d    = opnd_q;
    mdr_d     = mdr_q;
    ac_d      = ac_q;
    illegal_d = illegal_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = pc_q;

    case (state_q)
      StFetch0: begin
        // rst_n qualifies the strobe so it stays low while reset is held with run high.
        if (run && rst_n) begin
          mem_rd  = 1'b1;
          state_d = StFetch1;
        end
      end
      StFetch1: begin
        ir_d     = mem_rdata;
        mem_rd   = 1'b1;
        mem_addr = pc_q + 8'd1;
        pc_d     = pc_q + 8'd1;
        state_d  = StFetch2;
      end
      StFetch2: begin
        opnd_d  = mem_rdata;
        pc_d    = pc_q + 8'd1;
        state_d = is_mem_op(ir_q) ? StMemRd : StExec;
      end
      StMemRd: begin
        mem_rd   = 1'b1;
        mem_addr = opnd_q;
        state_d  = StMemCap;
      end
      StMemCap: begin
        mdr_d   = mem_rdata;
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch0;
        case (ir_q)
          8'h00: begin
          end
          8'h01, 8'h02, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
          8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F: ac_d = alu_zout;
          8'h03: begin
            mem_wr   = 1'b1;
            mem_addr = opnd_q;
          end
          8'h04: state_d = StHalt;
          8'h10: pc_d = opnd_q;
          8'h11: if (alu_nflg)  pc_d = opnd_q;
          8'h12: if (!alu_nflg) pc_d = opnd_q;
          8'h13: if (alu_zflg)  pc_d = opnd_q;
          8'h14: if (!alu_zflg) pc_d = opnd_q;
          default: begin
            illegal_d = 1'b1;
`ifdef SEQ_ILLEGAL_TRAP_EN
            state_d   = StHalt;
`else
            state_d   = StFetch0;
`endif
          end
        endcase
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch0;
    endcase
  end

  assign mem_wdata  = ac_q;
  assign alu_opcode = ir_q;
  assign alu_mdr    = mdr_q;
  assign alu_ac     = ac_q;
  assign alu_value  = opnd_q;
  assign alu_pc     = pc_q;
  assign alu_addr   = opnd_q;
  assign halted     = (state_q == StHalt);
  assign illegal    = illegal_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller that drives the 8-bit ALU.
- Fetches two-byte instructions (opcode, operand) from a synchronous memory and presents opcode/mdr/ac/value/pc/addr to the ALU.
- Writes the ALU result (zout) back into AC, performs stores, and resolves branches using the ALU's nflg/zflg.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- MEM_LAT, 1, memory read latency in cycles; only 1 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  sampled only in FETCH0; low holds the FSM in FETCH0.
- mem_addr  out  8  memory address.
- mem_rd  out  1  read strobe; mem_rdata is valid the cycle after.
- mem_rdata  in  8  read data.
- mem_wr  out  1  one-cycle write strobe.
- mem_wdata  out  8  write data (= AC).
- alu_opcode  out  8  IR to the ALU.
- alu_mdr  out  8  MDR register.
- alu_ac  out  8  AC register.
- alu_value  out  8  operand register (immediate view).
- alu_pc  out  8  PC register.
- alu_addr  out  8  operand register (address view).
- alu_zout  in  8  ALU result.
- alu_nflg  in  1  AC[7] from the ALU.
- alu_zflg  in  1  AC==0 from the ALU.
- halted  out  1  high in the HALT state.
- illegal  out  1  sticky flag: an undefined opcode was executed.

Behaviour:
- Reset (async, rst_n low): state=FETCH0, PC=RESET_PC, IR=OPND=MDR=AC=0, mem_rd=mem_wr=0, halted=0, illegal=0. An in-flight write is dropped immediately.
- States and transitions:
  - FETCH0: if run, assert mem_rd with mem_addr=PC, go to FETCH1; else idle.
  - FETCH1: IR<=mem_rdata; assert mem_rd with mem_addr=PC+1; PC<=PC+1; go to FETCH2.
  - FETCH2: OPND<=mem_rdata; PC<=PC+1; go to MEMRD for memory-operand ops, otherwise EXEC.
  - MEMRD: mem_rd, mem_addr=OPND; go to MEMCAP.
  - MEMCAP: MDR<=mem_rdata; go to EXEC.
  - EXEC: perform the opcode action (below); go to FETCH0, or HALT for opcode 04.
- Opcode groups:
  - Memory-operand ops: 01, 05, 07, 09, 0A, 0B, 0C, 0D.
  - Immediate ops: 02, 06, 08, 0E, 0F.
- EXEC actions:
  - 01, 02, 05–0F: AC<=alu_zout.
  - 03 (STORE): mem_wr=1, mem_addr=OPND, mem_wdata=AC; AC unchanged.
  - 00: NOP.
  - 04: enter HALT.
  - 10: PC<=OPND unconditionally.
  - 11: PC<=OPND if alu_nflg.
  - 12: PC<=OPND if !alu_nflg.
  - 13: PC<=OPND if alu_zflg.
  - 14: PC<=OPND if !alu_zflg.
  - 15–FF: illegal=1 (sticky), treated as NOP.
- Latency: immediate, STORE, branch, NOP and HALT take 4 cycles (FETCH0–EXEC); memory-operand ops take 6 cycles.
- Flags: the ALU computes nflg/zflg from the current AC. A branch sees the AC written by the prior instruction.
- PC arithmetic is modulo 256: PC=FF fetches its operand from 00, and the next instruction starts at 01.
- HALT is absorbing: halted=1, no memory strobes; exit only via rst_n.
- mem_rd and mem_wr are never high in the same cycle.
- run low mid-instruction has no effect; the instruction completes.

Optional Feature:
- Macro: SEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode sets illegal=1 and enters HALT (halted=1) instead of executing as a NOP.
- Undefined: illegal=1 is set and execution continues at the next instruction.

Test Plan:
- Mem{00:02,01:05,02:06,03:03,04:04} (LOADI 5; ADDI 3; HALT), run=1 → AC=08 after cycle 8; halted=1 at cycle 12; PC=06.
- Mem{00:01,01:80,02:03,03:40,04:04,05:00}, mem[80]=7F (LOAD 80; STORE 40; HALT) → mem_wr pulse with addr=40, wdata=7F at cycle 10; LOAD takes exactly 6 cycles.
- LOADI 00; JZ 20 → next FETCH0 has PC=20. LOADI 01; JZ 20 → no branch, PC=sequential.
- LOADI 80; JN 30 → PC=30. JP 30 with AC=80 → not taken.
- Opcode 3C → illegal=1. Without the macro, execution continues and halted=0. With the macro, halted=1 and no further mem_rd.
- Assert rst_n low during the MEMRD of a LOAD → outputs return to reset values immediately. After release, the first fetch is from RESET_PC. Also check the PC wrap: instruction at FF fetches its operand from 00.
